// File: rtl/trng_word_assembler.sv
// Von Neumann debiaser and 32-bit word packer for the TRNG path feeding the key loader.
// A sticky repetition-count health test blocks word delivery once the raw source sticks.
module trng_word_assembler #(
  parameter int unsigned REP_LIMIT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        raw_valid,
  input  logic        raw_bit,
  input  logic        trng_request,
  output logic        trng_ready,
  output logic [31:0] trng_bit,
  output logic        health_fail,
  output logic        word_avail
);

  localparam logic [5:0] REP_LIM = 6'(REP_LIMIT);

  // Pair stage
  logic        have_first_q, have_first_d;
  logic        first_q, first_d;

  // Accumulator
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        acc_full_q, acc_full_d;

  // Output buffer and delivery
  logic [31:0] out_word_q, out_word_d;
  logic        word_avail_q, word_avail_d;
  logic        trng_ready_q, trng_ready_d;
  logic [31:0] trng_bit_q, trng_bit_d;

  // Health test
  logic        last_raw_q, last_raw_d;
  logic [5:0]  rep_cnt_q, rep_cnt_d;
  logic        health_fail_q, health_fail_d;

  logic        emit;
  logic        trip;
  logic        deliver;
  logic        transfer;
  logic [5:0]  rep_upd;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

  always_comb begin
    rep_upd = (raw_bit == last_raw_q) ? sat_inc6(rep_cnt_q) : 6'd1;
    trip    = raw_valid && (rep_upd >= REP_LIM);
    emit    = raw_valid && have_first_q && (first_q != raw_bit);
    transfer = acc_full_q && !word_avail_q;
    deliver  = trng_request && word_avail_q && !trng_ready_q && !health_fail_q && !trip;
  end

  always_comb begin
    have_first_d  = have_first_q;
    first_d       = first_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    acc_full_d    = acc_full_q;
    out_word_d    = out_word_q;
    word_avail_d  = word_avail_q;
    trng_ready_d  = 1'b0;
    trng_bit_d    = trng_bit_q;
    last_raw_d    = last_raw_q;
    rep_cnt_d     = rep_cnt_q;
    health_fail_d = health_fail_q;

    if (raw_valid) begin
      last_raw_d = raw_bit;
      rep_cnt_d  = rep_upd;
      if (!have_first_q) begin
        first_d      = raw_bit;
        have_first_d = 1'b1;
      end else begin
        have_first_d = 1'b0;
      end
    end

    // Bits arriving while a complete word waits in the accumulator are dropped.
    if (emit && !acc_full_q) begin
      acc_d = {acc_q[30:0], first_q};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        acc_full_d = 1'b1;
      end
    end

    if (transfer) begin
      out_word_d   = acc_q;
      word_avail_d = 1'b1;
      acc_full_d   = 1'b0;
    end

    if (deliver) begin
      trng_ready_d = 1'b1;
      trng_bit_d   = out_word_q;
      word_avail_d = 1'b0;
    end

    // A trip, or the sticky failure afterwards, flushes everything upstream of delivery.
    if (trip || health_fail_q) begin
      health_fail_d = 1'b1;
      have_first_d  = 1'b0;
      first_d       = 1'b0;
      acc_d         = '0;
      cnt_d         = '0;
      acc_full_d    = 1'b0;
      word_avail_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_first_q  <= 1'b0;
      first_q       <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      acc_full_q    <= 1'b0;
      out_word_q    <= '0;
      word_avail_q  <= 1'b0;
      trng_ready_q  <= 1'b0;
      trng_bit_q    <= '0;
      last_raw_q    <= 1'b0;
      rep_cnt_q     <= '0;
      health_fail_q <= 1'b0;
    end else begin
      have_first_q  <= have_first_d;
      first_q       <= first_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      acc_full_q    <= acc_full_d;
      out_word_q    <= out_word_d;
      word_avail_q  <= word_avail_d;
      trng_ready_q  <= trng_ready_d;
      trng_bit_q    <= trng_bit_d;
      last_raw_q    <= last_raw_d;
      rep_cnt_q     <= rep_cnt_d;
      health_fail_q <= health_fail_d;
    end
  end

  assign trng_ready  = trng_ready_q;
  assign trng_bit    = trng_bit_q;
  assign health_fail = health_fail_q;
  assign word_avail  = word_avail_q;

endmodule

// File: tb/tb_trng_word_assembler.sv
// Scoreboarded bench: a queue-based reference predicts deliveries, a monitor checks each pulse.
module tb_trng_word_assembler;

  localparam int REP_LIMIT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        raw_valid = 1'b0;
  logic        raw_bit = 1'b0;
  logic        trng_request = 1'b0;
  logic        trng_ready;
  logic [31:0] trng_bit;
  logic        health_fail;
  logic        word_avail;

  int tests = 0;
  int fails = 0;

  trng_word_assembler #(.REP_LIMIT(REP_LIMIT)) dut (
    .clk(clk), .rst(rst), .raw_valid(raw_valid), .raw_bit(raw_bit),
    .trng_request(trng_request), .trng_ready(trng_ready), .trng_bit(trng_bit),
    .health_fail(health_fail), .word_avail(word_avail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits collected in a queue, the word built only when complete.
  bit          m_have, m_first, m_last, m_accfull, m_bufv, m_ready, m_fail;
  int          m_run;
  bit          acc_bits[$];
  logic [31:0] m_buf, m_out;
  logic [31:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_have = 0; m_first = 0; m_last = 0; m_accfull = 0; m_bufv = 0;
      m_ready = 0; m_fail = 0; m_run = 0; m_buf = '0; m_out = '0;
      acc_bits.delete();
      exp_q.delete();
    end else begin
      bit trip, dlv, xfer, em, ebit;
      trip = 0;
      em = 0;
      ebit = m_first;
      if (raw_valid) begin
        if (m_run == 0 || raw_bit != m_last) m_run = 1;
        else if (m_run < 63) m_run = m_run + 1;
        m_last = raw_bit;
        trip = (m_run >= REP_LIMIT);
        em = m_have && (m_first != raw_bit);
      end
      dlv  = trng_request && m_bufv && !m_ready && !m_fail && !trip;
      xfer = m_accfull && !m_bufv;
      if (xfer) begin
        for (int i = 0; i < 32; i++) m_buf[31-i] = acc_bits[i];
        acc_bits.delete();
        m_accfull = 0;
        m_bufv = 1;
      end else if (em && !m_accfull) begin
        acc_bits.push_back(ebit);
        if (acc_bits.size() == 32) m_accfull = 1;
      end
      if (dlv) begin
        m_ready = 1;
        m_out = m_buf;
        m_bufv = 0;
        exp_q.push_back(m_buf);
      end else begin
        m_ready = 0;
      end
      if (raw_valid) begin
        if (!m_have) begin m_first = raw_bit; m_have = 1; end
        else m_have = 0;
      end
      if (trip || m_fail) begin
        m_fail = 1; m_have = 0; m_accfull = 0; m_bufv = 0;
        acc_bits.delete();
      end
    end
  end

  // Monitor: every pulse must match the oldest predicted delivery.
  always @(negedge clk) begin
    if (trng_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got word %h expected no pulse at %0t", trng_bit, $time);
      end else begin
        logic [31:0] w;
        w = exp_q.pop_front();
        chk("delivered_word", trng_bit, w);
      end
    end
  end

  always @(negedge clk) begin
    chk("trng_ready", {31'b0, trng_ready}, {31'b0, m_ready});
    chk("word_avail", {31'b0, word_avail}, {31'b0, m_bufv});
    chk("health_fail", {31'b0, health_fail}, {31'b0, m_fail});
    chk("trng_bit_hold", trng_bit, m_out);
  end

  task automatic send(input bit b);
    raw_valid = 1'b1;
    raw_bit   = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    raw_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic feed_word(input logic [31:0] w, input bit interleave);
    for (int i = 31; i >= 0; i--) begin
      if (interleave && (i % 2 == 0)) begin
        bit d;
        d = bit'($urandom_range(0, 1));
        send(d); send(d);
      end
      send(w[i]); send(~w[i]);
    end
    raw_valid = 1'b0;
  endtask

  task automatic request(input int n);
    trng_request = 1'b1;
    repeat (n) @(negedge clk);
    trng_request = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", {31'b0, trng_ready}, 32'd0);
    chk("rst_bit", trng_bit, 32'd0);
    chk("rst_fail", {31'b0, health_fail}, 32'd0);
    chk("rst_avail", {31'b0, word_avail}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    idle(2);

    // Single word, request held three cycles.
    feed_word(32'hA5A5A5A5, 1'b0);
    idle(3);
    chk("a5_avail", {31'b0, word_avail}, 32'd1);
    request(3);
    idle(3);
    chk("a5_held", trng_bit, 32'hA5A5A5A5);

    // Same word with discarded 00/11 pairs interleaved.
    feed_word(32'hA5A5A5A5, 1'b1);
    idle(3);
    request(2);
    idle(2);
    chk("a5_interleaved", trng_bit, 32'hA5A5A5A5);

    // Back-pressure: third word is dropped.
    feed_word(32'h11111111, 1'b0);
    feed_word(32'h22222222, 1'b0);
    feed_word(32'h33333333, 1'b0);
    idle(3);
    request(1);
    idle(4);
    chk("bp_first", trng_bit, 32'h11111111);
    request(1);
    idle(4);
    chk("bp_second", trng_bit, 32'h22222222);
    chk("bp_third_dropped", {31'b0, word_avail}, 32'd0);

    // Reset mid-stream, then 64 raw bits needed before a word.
    feed_word(32'hDEADBEEF, 1'b0);
    raw_valid = 1'b1;
    do_reset();
    for (int i = 0; i < 31; i++) begin send(1'b1); send(1'b0); end
    idle(3);
    chk("post_rst_62bits", {31'b0, word_avail}, 32'd0);
    send(1'b0); send(1'b1);
    idle(2);
    chk("post_rst_64bits", {31'b0, word_avail}, 32'd1);
    request(1);
    idle(2);
    chk("post_rst_word", trng_bit, 32'hFFFFFFFE);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      raw_valid    = ($urandom_range(0, 3) != 0);
      raw_bit      = bit'($urandom_range(0, 1));
      trng_request = ($urandom_range(0, 7) == 0);
      if (c == 1500) begin
        do_reset();
      end else begin
        @(negedge clk);
      end
    end
    raw_valid = 1'b0;
    trng_request = 1'b0;
    idle(4);

    // Health test: a buffered word, then 32 consecutive ones.
    do_reset();
    feed_word(32'hA5A5A5A5, 1'b0);
    idle(3);
    send(1'b0);
    for (int i = 0; i < 31; i++) send(1'b1);
    chk("hf_before_32nd", {31'b0, health_fail}, 32'd0);
    send(1'b1);
    idle(1);
    chk("hf_tripped", {31'b0, health_fail}, 32'd1);
    chk("hf_avail_cleared", {31'b0, word_avail}, 32'd0);
    feed_word(32'h5A5A5A5A, 1'b0);
    request(6);
    idle(3);
    chk("hf_sticky", {31'b0, health_fail}, 32'd1);
    chk("hf_no_pulse", trng_bit, 32'd0);
    do_reset();
    idle(2);
    chk("hf_cleared_by_rst", {31'b0, health_fail}, 32'd0);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_words: got %0d undelivered expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
